// File: rtl/palette_engine.sv
// Palette lookup with a register-based colour table, a 2-stage scaling pipeline
// and a brightness fade FSM that steps the shared scale every FADE_DIV cycles.
module palette_engine #(
  parameter int INDEX_W  = 2,
  parameter int COLOR_W  = 8,
  parameter int BRIGHT_W = 4,
  parameter int FADE_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INDEX_W-1:0] palette_index,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [COLOR_W-1:0] wr_red,
  input  logic [COLOR_W-1:0] wr_green,
  input  logic [COLOR_W-1:0] wr_blue,
  input  logic               fade_req,
  input  logic               fade_dir,
  output logic               out_valid,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               fade_busy,
  output logic               fade_done
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int PROD_W  = COLOR_W + BRIGHT_W + 1;
  localparam int LUT_W   = COLOR_W + INDEX_W;
  localparam int CNT_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [BRIGHT_W:0] SCALE_FULL = {1'b1, {BRIGHT_W{1'b0}}};
  localparam logic [BRIGHT_W:0] SCALE_ZERO = {(BRIGHT_W + 1){1'b0}};
  localparam logic [BRIGHT_W:0] SCALE_ONE  = {{BRIGHT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FADE_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_UP   = 2'd2
  } fade_state_t;

  // Reset content: a fixed gamma-like ramp for the default geometry, a linear grey ramp otherwise.
  function automatic logic [RGB_W-1:0] init_entry(input int idx);
    logic [LUT_W-1:0]   num_v;
    logic [COLOR_W-1:0] lvl_v;
    logic [RGB_W-1:0]   rgb_v;
    num_v = LUT_W'(idx) * LUT_W'({COLOR_W{1'b1}});
    lvl_v = COLOR_W'(num_v / LUT_W'(ENTRIES - 1));
    rgb_v = {3{lvl_v}};
    if (INDEX_W == 2 && COLOR_W == 8) begin
      case (idx)
        32'd0:   rgb_v = RGB_W'(24'h000000);
        32'd1:   rgb_v = RGB_W'(24'h525451);
        32'd2:   rgb_v = RGB_W'(24'hd8dad7);
        32'd3:   rgb_v = RGB_W'(24'hffffff);
        default: rgb_v = {3{lvl_v}};
      endcase
    end
    return rgb_v;
  endfunction

  function automatic logic [COLOR_W-1:0] scale_ch(input logic [COLOR_W-1:0] ch,
                                                  input logic [BRIGHT_W:0]  sc);
    return COLOR_W'((PROD_W'(ch) * PROD_W'(sc)) >> BRIGHT_W);
  endfunction

  logic [RGB_W-1:0]   tab_r [ENTRIES];
  logic [RGB_W-1:0]   wr_rgb_s;
  logic [RGB_W-1:0]   rd_rgb_s;
  logic               s1_valid_r;
  logic [RGB_W-1:0]   s1_rgb_r;
  logic               out_valid_r;
  logic [COLOR_W-1:0] red_r;
  logic [COLOR_W-1:0] green_r;
  logic [COLOR_W-1:0] blue_r;
  fade_state_t        state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BRIGHT_W:0]  scale_r;
  logic               fade_busy_r;
  logic               fade_done_r;

  assign wr_rgb_s = {wr_red, wr_green, wr_blue};

  // Stage-1 read data, forwarding a same-cycle write to the same entry.
  always_comb begin
    rd_rgb_s = tab_r[palette_index];
    if (wr_en && (wr_index == palette_index)) begin
      rd_rgb_s = wr_rgb_s;
    end else begin
      rd_rgb_s = tab_r[palette_index];
    end
  end

  // Colour table storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tab_r[i] <= init_entry(i);
      end
    end else if (wr_en) begin
      tab_r[wr_index] <= wr_rgb_s;
    end
  end

  // Two-stage lookup pipeline; stage 2 applies the scale in effect at that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_rgb_r    <= {RGB_W{1'b0}};
      out_valid_r <= 1'b0;
      red_r       <= {COLOR_W{1'b0}};
      green_r     <= {COLOR_W{1'b0}};
      blue_r      <= {COLOR_W{1'b0}};
    end else begin
      s1_valid_r  <= in_valid;
      out_valid_r <= s1_valid_r;
      if (in_valid) begin
        s1_rgb_r <= rd_rgb_s;
      end
      if (s1_valid_r) begin
        red_r   <= scale_ch(s1_rgb_r[RGB_W-1 -: COLOR_W], scale_r);
        green_r <= scale_ch(s1_rgb_r[2*COLOR_W-1 -: COLOR_W], scale_r);
        blue_r  <= scale_ch(s1_rgb_r[COLOR_W-1:0], scale_r);
      end
    end
  end

  // Fade FSM: the step counter paces scale changes; reaching the target ends the fade.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      scale_r     <= SCALE_FULL;
      fade_busy_r <= 1'b0;
      fade_done_r <= 1'b0;
    end else begin
      fade_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fade_req) begin
            state_r     <= fade_dir ? ST_UP : ST_DOWN;
            cnt_r       <= CNT_ZERO;
            fade_busy_r <= 1'b1;
          end else begin
            fade_busy_r <= 1'b0;
          end
        end
        ST_DOWN: begin
          if (scale_r == SCALE_ZERO) begin
            state_r     <= ST_IDLE;
            fade_busy_r <= 1'b0;
            fade_done_r <= 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= CNT_ZERO;
            scale_r <= scale_r - SCALE_ONE;
            if (scale_r == SCALE_ONE) begin
              state_r     <= ST_IDLE;
              fade_busy_r <= 1'b0;
              fade_done_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          end
        end
        ST_UP: begin
          if (scale_r == SCALE_FULL) begin
            state_r     <= ST_IDLE;
            fade_busy_r <= 1'b0;
            fade_done_r <= 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= CNT_ZERO;
            scale_r <= scale_r + SCALE_ONE;
            if (scale_r == (SCALE_FULL - SCALE_ONE)) begin
              state_r     <= ST_IDLE;
              fade_busy_r <= 1'b0;
              fade_done_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= CNT_ZERO;
          fade_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign red       = red_r;
  assign green     = green_r;
  assign blue      = blue_r;
  assign fade_busy = fade_busy_r;
  assign fade_done = fade_done_r;

endmodule

// File: doc/palette_engine.md
PALETTE_ENGINE -- requirements
Module: palette_engine

Interface
REQ-001 Parameter INDEX_W, default 2, sets index width; the table SHALL hold 2**INDEX_W entries.
REQ-002 Parameter COLOR_W, default 8, sets the width of each colour channel.
REQ-003 Parameter BRIGHT_W, default 4, sets fade resolution; scale range SHALL be 0..2**BRIGHT_W.
REQ-004 Parameter FADE_DIV, default 1024, sets clock cycles per fade step; it SHALL be at least 1.
REQ-005 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 in_valid  input  1  lookup request strobe.
REQ-008 palette_index  input  INDEX_W  entry to look up.
REQ-009 wr_en  input  1  table write strobe.
REQ-010 wr_index  input  INDEX_W  entry to write.
REQ-011 wr_red / wr_green / wr_blue  input  COLOR_W each  write data.
REQ-012 fade_req  input  1  one-cycle fade start request.
REQ-013 fade_dir  input  1  fade direction: 0 fades to black, 1 fades to full.
REQ-014 out_valid  output  1  red/green/blue valid this cycle.
REQ-015 red / green / blue  output  COLOR_W each  scaled colour.
REQ-016 fade_busy  output  1  fade FSM not in IDLE.
REQ-017 fade_done  output  1  one-cycle pulse at fade completion.

Function
REQ-018 The table SHALL be register-based; wr_en SHALL write all three channels of entry wr_index at the clock edge.
REQ-019 Lookup latency SHALL be exactly 2 cycles: in_valid at cycle N yields out_valid=1 at N+2; there is no backpressure.
REQ-020 Stage 1 SHALL register the entry at palette_index; if wr_en=1 and wr_index equals palette_index in the same cycle, stage 1 SHALL capture the write data (bypass).
REQ-021 Stage 2 SHALL register each channel as (channel * scale) >> BRIGHT_W, with the product held at COLOR_W+BRIGHT_W+1 bits and no overflow, using the scale value current at stage 2.
REQ-022 scale = 2**BRIGHT_W SHALL pass colours unchanged; scale = 0 SHALL output zero on all channels.
REQ-023 When out_valid=0, red/green/blue SHALL hold their last values.
REQ-024 The fade FSM SHALL have three states: IDLE, DOWN and UP.
REQ-025 In IDLE, fade_req=1 SHALL enter DOWN (fade_dir=0) or UP (fade_dir=1) and clear the step counter.
REQ-026 fade_req SHALL be ignored outside IDLE.
REQ-027 In DOWN/UP, a step counter SHALL count 0..FADE_DIV-1; on wrap, scale SHALL change by 1 (decrement in DOWN, increment in UP).
REQ-028 When scale reaches 0 in DOWN, or 2**BRIGHT_W in UP, the FSM SHALL return to IDLE and pulse fade_done for one cycle.
REQ-029 If a fade is requested while scale already equals its target, the FSM SHALL enter the state and, on the next cycle, return to IDLE with a fade_done pulse and no scale change.
REQ-030 Scale SHALL never wrap below 0 or above 2**BRIGHT_W.
REQ-031 Table writes and lookups SHALL be legal during fades and SHALL not affect fade timing.

Reset
REQ-032 On rst, out_valid, fade_busy and fade_done SHALL be 0, and red/green/blue SHALL be 0.
REQ-033 On rst, the FSM SHALL enter IDLE, the step counter SHALL clear, scale SHALL be 2**BRIGHT_W, and both pipeline valid bits SHALL clear.
REQ-034 On rst with INDEX_W=2 and COLOR_W=8, the table SHALL load: entry 0 = 00/00/00, entry 1 = 52/54/51, entry 2 = d8/da/d7, entry 3 = ff/ff/ff.
REQ-035 On rst with any other parameter set, entry i SHALL load floor(i*(2**COLOR_W-1)/(2**INDEX_W-1)) on all three channels.
REQ-036 Reset asserted mid-fade or mid-lookup SHALL abort the operation; no out_valid or fade_done SHALL follow it.

Verification
REQ-037 Reset defaults: release rst, then lookup indices 0..3 back-to-back -> out_valid for 4 cycles starting 2 cycles later, with colours 000000, 525451, d8dad7, ffffff.
REQ-038 Write then read: write index 2 = 10/20/30, read index 2 on the next cycle -> 102030; read index 2 in the same cycle as the write -> 102030 via bypass.
REQ-039 Fade down: FADE_DIV=2, BRIGHT_W=4, fade_req with dir=0 -> fade_busy for 32 cycles, then one fade_done pulse; index 3 reads ff mid-fade at scale 8 -> 7f; at scale 0 -> 00.
REQ-040 Fade request in the wrong state: fade_req with dir=1 at scale 16 -> fade_done 1 cycle later and scale stays 16; fade_req during a busy fade -> ignored and timing unchanged.
REQ-041 Reset mid-fade: assert rst at scale 5 -> fade_busy=0, scale=16, and no fade_done pulse.
